// File: rtl/serial_restador.sv
// Bit-serial unsigned subtractor (A - B), LSB first: one full-subtractor cell
// plus a borrow flip-flop, with start/busy/done handshaking.
module serial_restador #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] r_sh_q;
  logic [WIDTH-1:0] r_sh_d;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic             borrow_d;
  logic             diff_bit;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q;

  always_comb begin
    diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    borrow_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
    r_sh_d   = {diff_bit, r_sh_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      r_sh_q       <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_start) begin
            a_sh_q   <= in_a;
            b_sh_q   <= in_b;
            r_sh_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          r_sh_q   <= r_sh_d;
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + CW'(1);
          // Final bit is folded in here so the result is valid alongside done.
          if (cnt_q == CW'(WIDTH - 1)) begin
            diff_q       <= r_sh_d;
            borrow_out_q <= borrow_d;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_busy   = busy_q;
  assign out_done   = done_q;
  assign out_diff   = diff_q;
  assign out_borrow = borrow_out_q;

endmodule

// File: tb/tb_serial_restador.sv
// Scoreboard bench for serial_restador: the driver pushes {borrow,diff} from a
// 9-bit arithmetic model, a forked monitor pops and compares on each done pulse.
module tb_serial_restador;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_start = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_busy;
  logic         out_done;
  logic [W-1:0] out_diff;
  logic         out_borrow;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  logic [W:0] exp_q[$];
  logic [W:0] exp_hold = '0;

  always #5 clk = ~clk;

  serial_restador #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_start  (in_start),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_busy  (out_busy),
    .out_done  (out_done),
    .out_diff  (out_diff),
    .out_borrow(out_borrow)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [W:0] e;
    int pend;
    forever begin
      @(negedge clk);
      if (out_done) begin
        n_done++;
        pend = exp_q.size();
        chk("op_pending_at_done", 32'(pend > 0), 32'd1);
        if (pend > 0) begin
          e = exp_q.pop_front();
          chk("result", 32'({out_borrow, out_diff}), 32'(e));
          exp_hold = e;
        end
        chk("busy_during_done", 32'(out_busy), 32'd0);
      end else begin
        chk("held_result", 32'({out_borrow, out_diff}), 32'(exp_hold));
      end
    end
  endtask

  // inj_at: cycle in which a second start is pulsed; rst_at: cycle of reset.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj_at, input int rst_at);
    int busy_n;
    int lat;
    busy_n = 0;
    lat    = 0;
    @(posedge clk); #1;
    in_start = 1'b1; in_a = a; in_b = b;
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    in_start = 1'b0;
    for (int c = 1; c <= 3 * W; c++) begin
      @(negedge clk);
      if (out_busy) busy_n++;
      if (out_done) begin
        lat = c;
        break;
      end
      if (c + 1 == rst_at) begin
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        exp_hold = '0;
        #1;
        chk("rst_diff", 32'(out_diff), 32'd0);
        chk("rst_borrow", 32'(out_borrow), 32'd0);
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_done", 32'(out_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3 * W) @(posedge clk);
        return;
      end
      if (c + 1 == inj_at) begin
        @(posedge clk); #1;
        in_start = 1'b1; in_a = 8'h01; in_b = 8'h01;
      end else if (c == inj_at) begin
        @(posedge clk); #1;
        in_start = 1'b0;
      end
    end
    chk("latency", 32'(lat), 32'(W + 1));
    chk("busy_cycles", 32'(busy_n), 32'(W));
  endtask

  task automatic back_to_back(input int n_ops);
    int d0;
    logic [W-1:0] a;
    logic [W-1:0] b;
    d0 = n_done;
    @(posedge clk); #1;
    a = W'($urandom); b = W'($urandom);
    in_start = 1'b1; in_a = a; in_b = b;
    exp_q.push_back(model(a, b));
    for (int k = 1; k < n_ops; k++) begin
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom);
      in_a = a; in_b = b;
      exp_q.push_back(model(a, b));
      repeat (W + 1) @(posedge clk);
    end
    @(posedge clk); #1;
    in_start = 1'b0;
    repeat (2 * W) @(posedge clk);
    @(negedge clk);
    chk("b2b_done_count", 32'(n_done - d0), 32'(n_ops));
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_diff", 32'(out_diff), 32'd0);
    chk("reset_borrow", 32'(out_borrow), 32'd0);
    chk("reset_busy", 32'(out_busy), 32'd0);
    chk("reset_done", 32'(out_done), 32'd0);
    rst = 1'b0;
    fork
      monitor();
    join_none

    run_op(8'h5A, 8'h23, 0, 0);
    run_op(8'h10, 8'h20, 0, 0);
    run_op(8'h00, 8'h01, 0, 0);
    run_op(8'hFF, 8'hFF, 0, 0);
    run_op(8'h00, 8'hFF, 0, 0);
    run_op(8'h5A, 8'h23, 4, 0);
    repeat (2 * W) @(posedge clk);
    run_op(8'hC3, 8'h3C, 0, 5);
    run_op(8'h5A, 8'h23, 0, 0);
    back_to_back(5);

    for (int i = 0; i < 1500; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
      run_op(a, b, 0, 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
